coreapb3_resp_mux_wdog: RTL
===========================

// Module: coreapb3_resp_mux_wdog
// PURPOSE
//  Parametrised APB3 slave-response multiplexer with transfer watchdog. Sits between the address
//  decoder (one-hot slave selects) and the master-side APB3 port. Routes PRDATA/PREADY/PSLVERR from
//  the selected slave, flags unmapped/multi-select accesses, and terminates hung transfers with an error.
// PARAMETERS
//  NUM_SLAVES    17   number of slave ports, legal 2..32; SW = $clog2(NUM_SLAVES)
//  DATA_WIDTH    32   PRDATA width, legal 8/16/32
//  TIMEOUT       16   max wait-state cycles before forced error; 0 = watchdog disabled; max 65535
//  UNMAPPED_ERR  0    1: access with no slave selected returns PSLVERR=1; 0: returns PSLVERR=0
// PORTS
//  PCLK       in   1                     APB clock, all state on rising edge
//  PRESET     in   1                     asynchronous reset, active high
//  PSELS      in   NUM_SLAVES            one-hot slave selects from decoder
//  PENABLE    in   1                     master PENABLE (access phase)
//  PRDATAS    in   NUM_SLAVES*DATA_WIDTH slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//  PREADYS    in   NUM_SLAVES            slave PREADY
//  PSLVERRS   in   NUM_SLAVES            slave PSLVERR
//  PREADY     out  1                     muxed ready to master
//  PSLVERR    out  1                     muxed error to master
//  PRDATA     out  DATA_WIDTH            muxed read data to master
//  TOUT_PULSE out  1                     registered 1-cycle pulse on watchdog expiry
//  TOUT_SLV   out  SW                    index of slave that last timed out (sticky)
//  TOUT_CNT   out  8                     saturating count of watchdog expiries
// BEHAVIOUR
//  - Reset (PRESET=1, async): FSM=IDLE, wait counter=0, TOUT_PULSE=0, TOUT_SLV=0, TOUT_CNT=0;
//    PREADY=1, PSLVERR=0, PRDATA=0 forced while PRESET high.
//  - Select decode: sel_none = ~|PSELS; sel_multi = more than one bit set; idx = encoded one-hot.
//  - FSM states IDLE, ACCESS, TOUT.
//    IDLE:   |PSELS & ~PENABLE (setup) -> ACCESS, counter cleared, idx captured into cap_idx.
//    ACCESS: selected PREADYS[idx]=1 -> IDLE (or stay ACCESS if next setup already present);
//            PREADYS[idx]=0 & TIMEOUT!=0 & counter==TIMEOUT-1 -> TOUT; else counter+1.
//            PSELS deasserted (~|PSELS) -> IDLE, counter cleared.
//    TOUT:   one cycle; -> IDLE unconditionally. TOUT_PULSE=1 in the cycle after entry edge.
//  - Outputs are combinational (zero added latency) except in TOUT:
//    ACCESS, valid one-hot: PREADY=PREADYS[idx], PSLVERR=PSLVERRS[idx], PRDATA=PRDATAS[idx].
//    PREADY/PSLVERR are don't-care to master when PENABLE=0 but must still equal the mux above.
//    sel_none: PREADY=1, PSLVERR=UNMAPPED_ERR & PENABLE, PRDATA=0.
//    sel_multi: PREADY=1, PSLVERR=PENABLE, PRDATA=0 (never OR-combine slave data).
//    TOUT: PREADY=1, PSLVERR=1, PRDATA=0 regardless of slave outputs.
//  - A slave asserting PREADY in the same cycle the counter reaches TIMEOUT-1 wins: normal completion,
//    no timeout. Slave PREADY arriving during TOUT is ignored.
//  - On TOUT entry: TOUT_SLV<=cap_idx, TOUT_CNT<=TOUT_CNT+1 saturating at 255.
//  - TIMEOUT=0: counter held at 0, TOUT unreachable, TOUT_* stay at reset values.
//  - Counter width = $clog2(TIMEOUT+1); no wrap: it is cleared on every ACCESS entry/exit.
//  - Reset asserted mid-transfer: immediately IDLE with forced reset outputs; no TOUT pulse generated.
// TESTING
//  1 Zero-wait read: PSELS=1<<5, PRDATAS[5]=32'hA5A5_0005, PREADYS=all 1 -> PRDATA=32'hA5A5_0005,
//    PREADY=1, PSLVERR=0 in access cycle; TOUT_CNT stays 0.
//  2 Wait states: slave 16 holds PREADY=0 for 15 access cycles (TIMEOUT=16) then 1 with
//    PSLVERRS[16]=1 -> completes on cycle 16 with PSLVERR=1, no TOUT_PULSE.
//  3 Hung slave: slave 3 PREADY=0 forever, TIMEOUT=16 -> after 16 access cycles one cycle PREADY=1,
//    PSLVERR=1, PRDATA=0; next cycle TOUT_PULSE=1, TOUT_SLV=3, TOUT_CNT=1.
//  4 Unmapped/multi: PSELS=0, PENABLE=1 with UNMAPPED_ERR=0 -> PREADY=1,PSLVERR=0,PRDATA=0;
//    UNMAPPED_ERR=1 -> PSLVERR=1; PSELS=17'h00011 -> PREADY=1, PSLVERR=1, PRDATA=0.
//  5 Reset mid-wait: assert PRESET at wait cycle 10 of a hung transfer, release, rerun case 1 ->
//    outputs forced 1/0/0 during reset, no TOUT_PULSE, TOUT_CNT=0, case 1 passes.
//  6 Saturation and disable: 300 hung transfers -> TOUT_CNT=255; TIMEOUT=0 build, hung slave for
//    1000 cycles -> PREADY stays 0, TOUT_PULSE never asserts.

Source files
------------

// File: rtl/coreapb3_resp_mux_wdog_if.sv
// Master-side APB3 response bundle plus the per-slave inputs and watchdog status.
interface coreapb3_resp_mux_wdog_if #(
  parameter int unsigned NUM_SLAVES = 17,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [NUM_SLAVES-1:0]            PSELS;
  logic                             PENABLE;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATAS;
  logic [NUM_SLAVES-1:0]            PREADYS;
  logic [NUM_SLAVES-1:0]            PSLVERRS;
  logic                             PREADY;
  logic                             PSLVERR;
  logic [DATA_WIDTH-1:0]            PRDATA;
  logic                             TOUT_PULSE;
  logic [SW-1:0]                    TOUT_SLV;
  logic [7:0]                       TOUT_CNT;

  // The response mux consumes slave-side signals and drives the master-side response.
  modport slave (
    input  PSELS, PENABLE, PRDATAS, PREADYS, PSLVERRS,
    output PREADY, PSLVERR, PRDATA, TOUT_PULSE, TOUT_SLV, TOUT_CNT
  );

  // The environment driving selects and slave responses.
  modport master (
    output PSELS, PENABLE, PRDATAS, PREADYS, PSLVERRS,
    input  PREADY, PSLVERR, PRDATA, TOUT_PULSE, TOUT_SLV, TOUT_CNT
  );
endinterface

// File: rtl/coreapb3_resp_mux_wdog.sv
// APB3 slave-response multiplexer with a wait-state watchdog that terminates hung transfers.
module coreapb3_resp_mux_wdog #(
  parameter int unsigned NUM_SLAVES   = 17,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned TIMEOUT      = 16,
  parameter bit          UNMAPPED_ERR = 1'b0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  coreapb3_resp_mux_wdog_if.slave      bus
);

  localparam int unsigned SW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          WDOG_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_TOUT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         cap_idx_q, cap_idx_d;
  logic [SW-1:0]         tout_slv_q, tout_slv_d;
  logic [7:0]            tout_cnt_q, tout_cnt_d;
  logic                  tout_pulse_q, tout_pulse_d;

  logic [SW-1:0]         sel_idx;
  logic                  sel_none, sel_multi, setup, ready_mux;
  logic                  oh_rdy, oh_err;
  logic [DATA_WIDTH-1:0] oh_data;
  logic [NUM_SLAVES-1:0] psels_m1;
  logic                  pready_c, pslverr_c;
  logic [DATA_WIDTH-1:0] prdata_c;

  // One-hot encode and gather the selected slave's response with constant slices.
  always_comb begin : sel_decode
    sel_idx = '0;
    oh_rdy  = 1'b0;
    oh_err  = 1'b0;
    oh_data = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (bus.PSELS[i]) begin
        sel_idx = sel_idx | SW'(i);
        oh_rdy  = oh_rdy | bus.PREADYS[i];
        oh_err  = oh_err | bus.PSLVERRS[i];
        oh_data = oh_data | bus.PRDATAS[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign psels_m1  = bus.PSELS - NUM_SLAVES'(1);
  assign sel_none  = ~|bus.PSELS;
  assign sel_multi = |(bus.PSELS & psels_m1);
  assign setup     = ~sel_none & ~bus.PENABLE;
  // Ready as seen by the master outside TOUT: bad selects always complete at once.
  assign ready_mux = (sel_none | sel_multi) ? 1'b1 : oh_rdy;

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Watchdog counter, captured index and timeout status registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q        <= '0;
      cap_idx_q    <= '0;
      tout_slv_q   <= '0;
      tout_cnt_q   <= '0;
      tout_pulse_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cap_idx_q    <= cap_idx_d;
      tout_slv_q   <= tout_slv_d;
      tout_cnt_q   <= tout_cnt_d;
      tout_pulse_q <= tout_pulse_d;
    end
  end

  // Next-state: transfer tracking and watchdog expiry; slave ready wins over expiry.
  always_comb begin : next_state
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_idx_d    = cap_idx_q;
    tout_slv_d   = tout_slv_q;
    tout_cnt_d   = tout_cnt_q;
    tout_pulse_d = (state_q == ST_TOUT);
    unique case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d   = ST_ACCESS;
          cnt_d     = '0;
          cap_idx_d = sel_idx;
        end
      end
      ST_ACCESS: begin
        if (sel_none) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (ready_mux) begin
          cnt_d = '0;
          if (setup) cap_idx_d = sel_idx;
          else       state_d   = ST_IDLE;
        end else if (WDOG_EN && (cnt_q == CW'(TIMEOUT - 1))) begin
          state_d    = ST_TOUT;
          cnt_d      = '0;
          tout_slv_d = cap_idx_q;
          if (tout_cnt_q != 8'hFF) tout_cnt_d = tout_cnt_q + 8'd1;
        end else if (WDOG_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_TOUT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output mux: zero-latency routing, forced error response in TOUT, quiet response in reset.
  always_comb begin : resp_mux
    pready_c  = 1'b1;
    pslverr_c = 1'b0;
    prdata_c  = '0;
    if (PRESET) begin
      pready_c = 1'b1;
    end else if (state_q == ST_TOUT) begin
      pslverr_c = 1'b1;
    end else if (sel_none) begin
      pslverr_c = UNMAPPED_ERR & bus.PENABLE;
    end else if (sel_multi) begin
      pslverr_c = bus.PENABLE;
    end else begin
      pready_c  = oh_rdy;
      pslverr_c = oh_err;
      prdata_c  = oh_data;
    end
  end

  assign bus.PREADY     = pready_c;
  assign bus.PSLVERR    = pslverr_c;
  assign bus.PRDATA     = prdata_c;
  assign bus.TOUT_PULSE = tout_pulse_q;
  assign bus.TOUT_SLV   = tout_slv_q;
  assign bus.TOUT_CNT   = tout_cnt_q;

endmodule
